// File: rtl/wash_program_sequencer.sv
// -----------------------------------------------------------------------------
// wash_program_sequencer
//   Front-end controller for the washing machine. It turns debounced panel
//   button pulses into the 3-bit command code (state) and the 26-bit program
//   word (data) consumed by RunController. It also reacts to RunController's
//   hadFinish level.
//
//   Parameters
//     READY_CYC     cycles spent in READY before RUN (>=1)
//     AUTO_OFF_CYC  DONE dwell before auto power-off (>=1, AUTO_OFF_EN only)
//
//   Optional feature macro: AUTO_OFF_EN
//     When defined, DONE powers the block off after AUTO_OFF_CYC cycles.
//     When undefined, DONE holds until a button is pressed.
//
//   Ports
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     power_btn   in   1-cycle pulse, power toggle
//     start_btn   in   1-cycle pulse, start/pause/resume
//     mode_btn    in   1-cycle pulse, next program
//     hadFinish   in   level from RunController, cycle complete
//     state       out  command code to RunController
//     data        out  program word to RunController
//     mode        out  selected program index 0..5
//     done_pulse  out  1-cycle pulse on RUN->DONE
// -----------------------------------------------------------------------------
module wash_program_sequencer #(
    parameter int READY_CYC    = 10,
    parameter int AUTO_OFF_CYC = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_btn,
    input  logic        start_btn,
    input  logic        mode_btn,
    input  logic        hadFinish,
    output logic [2:0]  state,
    output logic [25:0] data,
    output logic [2:0]  mode,
    output logic        done_pulse
);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int RCW = (READY_CYC > 1) ? $clog2(READY_CYC) : 1;

    // Program ROM. Field boundaries are kept visible with underscores.
    function automatic logic [25:0] rom(input logic [2:0] idx);
        case (idx)
            3'd0:    rom = 26'b011_1010_100_101_011_1000_100_101;
            3'd1:    rom = 26'b001_0100_010_010_001_0100_010_010;
            3'd2:    rom = 26'b100_1111_101_110_100_1111_101_110;
            3'd3:    rom = 26'b000_0000_011_011_000_0000_011_011;
            3'd4:    rom = 26'b000_0000_000_101_000_0000_000_101;
            3'd5:    rom = 26'b111_1100_000_000_000_0000_000_000;
            default: rom = 26'd0;
        endcase
    endfunction

    logic [2:0]     state_q, state_d;
    logic [25:0]    data_q,  data_d;
    logic [2:0]     mode_q,  mode_d;
    logic           done_q,  done_d;
    logic [RCW-1:0] rcnt_q,  rcnt_d;
`ifdef AUTO_OFF_EN
    localparam int ACW = (AUTO_OFF_CYC > 1) ? $clog2(AUTO_OFF_CYC) : 1;
    logic [ACW-1:0] acnt_q,  acnt_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        rcnt_d  = rcnt_q;
`ifdef AUTO_OFF_EN
        acnt_d  = acnt_q;
`endif
        if (power_btn) begin
            // Power overrides every other input in every state.
            if (state_q == S_OFF) begin
                state_d = S_SELECT;
                mode_d  = 3'd0;
                data_d  = rom(3'd0);
            end else begin
                state_d = S_OFF;
                mode_d  = 3'd0;
                data_d  = '0;
                rcnt_d  = '0;
            end
        end else begin
            case (state_q)
                S_OFF: ;
                S_SELECT: begin
                    if (start_btn) begin
                        state_d = S_READY;
                        rcnt_d  = RCW'(READY_CYC - 1);
                    end else if (mode_btn) begin
                        mode_d = (mode_q == 3'd5) ? 3'd0 : mode_q + 3'd1;
                        data_d = rom(mode_d);
                    end
                end
                S_READY: begin
                    if (rcnt_q == '0) state_d = S_RUN;
                    else              rcnt_d  = rcnt_q - RCW'(1);
                end
                S_RUN: begin
                    // hadFinish beats start_btn when both arrive together.
                    if (hadFinish) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
`ifdef AUTO_OFF_EN
                        acnt_d  = ACW'(AUTO_OFF_CYC - 1);
`endif
                    end else if (start_btn) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_btn) state_d = S_RUN;
                end
                S_DONE: begin
                    if (start_btn) begin
                        state_d = S_SELECT;
`ifdef AUTO_OFF_EN
                    end else if (acnt_q == '0) begin
                        state_d = S_OFF;
                        mode_d  = 3'd0;
                        data_d  = '0;
                    end else begin
                        acnt_d = acnt_q - ACW'(1);
`endif
                    end
                end
                // Unused codes 4/7 recover to OFF.
                default: begin
                    state_d = S_OFF;
                    mode_d  = 3'd0;
                    data_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            data_q  <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            rcnt_q  <= '0;
`ifdef AUTO_OFF_EN
            acnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            rcnt_q  <= rcnt_d;
`ifdef AUTO_OFF_EN
            acnt_q  <= acnt_d;
`endif
        end
    end

    assign state      = state_q;
    assign data       = data_q;
    assign mode       = mode_q;
    assign done_pulse = done_q;

endmodule

// File: doc/wash_program_sequencer.md
# wash_program_sequencer

- Front-end controller for the washing machine that drives the `RunController` command interface.
- Turns debounced panel buttons into the 3-bit `state` code and the 26-bit program word `data` that `RunController` consumes.
- Closes the loop on `RunController`'s `hadFinish`.
- Sits between the panel/debounce logic and `RunController`, and is the sole source of `state`/`data`.

## Interface
- `READY_CYC`, default 10: cycles spent in READY before RUN (≥1).
- `AUTO_OFF_CYC`, default 200: DONE dwell before auto power-off (only with `AUTO_OFF_EN`, ≥1).
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `power_btn`  in  1  one-cycle pulse, power toggle.
- `start_btn`  in  1  one-cycle pulse, start/pause/resume.
- `mode_btn`  in  1  one-cycle pulse, next program.
- `hadFinish`  in  1  level from `RunController`; cycle complete.
- `state`  out  3  command code to `RunController`.
- `data`  out  26  program word to `RunController`.
- `mode`  out  3  selected program index 0..5.
- `done_pulse`  out  1  one-cycle pulse on RUN→DONE.

## Operation
- State codes:
  - OFF=0
  - SELECT=1
  - READY=2
  - RUN=3
  - PAUSE=5
  - DONE=6
  - Code 4 and code 7 are never driven.
- `data` field layout, MSB first, widths 3,4,3,3,3,4,3,3: f7 [25:23], f6 [22:19], f5 [18:16], f4 [15:13], f3 [12:10], f2 [9:6], f1 [5:3], f0 [2:0]. `RunController` interprets the fields.
- Program ROM, indexed by `mode`:
  - 0 standard: 011_1010_100_101_011_1000_100_101
  - 1 quick: 001_0100_010_010_001_0100_010_010
  - 2 heavy: 100_1111_101_110_100_1111_101_110
  - 3 rinse: 000_0000_011_011_000_0000_011_011
  - 4 spin: 000_0000_000_101_000_0000_000_101
  - 5 soak: 111_1100_000_000_000_0000_000_000
- Transitions, evaluated per cycle. Priority: `power_btn` > `hadFinish` > `start_btn` > `mode_btn`.
  - OFF: `power_btn` → SELECT, with `mode`=0 and `data`=ROM[0].
  - Any state other than OFF: `power_btn` → OFF, with `data`=0 and `mode`=0.
  - SELECT:
    - `mode_btn`: `mode`←(mode==5)?0:mode+1, and `data`←ROM[new mode] in the same edge.
    - `start_btn` → READY; the READY counter loads `READY_CYC`-1.
  - READY: counter decrements each cycle; at 0 → RUN. Buttons other than power are ignored.
  - RUN:
    - `hadFinish`=1 → DONE, and `done_pulse`=1 for that one cycle.
    - Otherwise `start_btn` → PAUSE.
  - PAUSE: `start_btn` → RUN. `hadFinish` is ignored.
  - DONE: `start_btn` → SELECT, keeping `mode` and `data`.
- `mode_btn` is ignored outside SELECT.
- `data` is frozen in every state except SELECT and OFF.

## Timing
- All outputs are registered.
- Reset values: `state`=0, `data`=0, `mode`=0, `done_pulse`=0, counters=0.
- Button-to-output latency is 1 edge: the pulse sampled at edge N is reflected in the outputs after edge N.
- `data` is valid no later than the edge on which `state` leaves SELECT. It is stable for the whole of READY, RUN, PAUSE and DONE.
- READY lasts exactly `READY_CYC` cycles.
- `hadFinish` is sampled only in RUN. If it is already high on RUN entry, DONE is reached on the next edge.
- Simultaneous events:
  - `power_btn` with any other input: power wins.
  - `hadFinish` with `start_btn` in RUN: DONE.
- `rst_n` low mid-run forces the reset values immediately, without waiting for a clock edge. Operation resumes from OFF on the first edge after release.

## Configuration
- `AUTO_OFF_EN` defined:
  - DONE loads a counter with `AUTO_OFF_CYC`-1.
  - At 0 the block goes to OFF, with `data`=0 and `mode`=0.
  - `start_btn` or `power_btn` before expiry takes priority and follows the normal transitions.
- `AUTO_OFF_EN` undefined: DONE holds indefinitely until `start_btn` or `power_btn`. No counter is synthesized.

## Test plan
- Power-up and mode wrap: `power_btn`, then 6× `mode_btn` → `state`=1; `mode` steps 1,2,3,4,5,0; `data` tracks the ROM entry each edge and returns to 011_1010_100_101_011_1000_100_101.
- Start sequence: mode 2, `start_btn` → `state`=2 for exactly 10 cycles, then 3; `data`=100_1111_101_110_100_1111_101_110 throughout.
- Pause/resume and finish:
  - In RUN, `start_btn` → 5; `hadFinish`=1 while paused → stays 5.
  - `start_btn` → 3, then next edge 6 with `done_pulse` high for one cycle.
- Priority collisions:
  - In RUN, `hadFinish` together with `start_btn` → 6.
  - In RUN, `power_btn` together with `hadFinish` → 0, `data`=0.
- Async reset: drop `rst_n` mid-READY → outputs are 0 before the next edge; after release, `start_btn` alone keeps `state`=0.
- Auto-off (macro on, `AUTO_OFF_CYC`=5): reach DONE, no input → `state`=0 after 5 cycles. With the macro off → `state` stays 6.
